uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
// Memory-mapped controller that owns the UART transmitter: the core pushes bytes through an MMIO register window.
// The block buffers them in a byte FIFO and sequences uart_tx's start/ready handshake, one byte at a time.
// A single writer (the core, via the memory bus) and a single reader (the sequencer) share the FIFO, so no IO register is driven from two places.
// Sits between the memory map decode and the uart_tx instance, in the core clock domain.
// PARAMETERS
// WORD_LEN     32  bus data width; only [7:0] is used for data pushes
// DEPTH        32  FIFO entries; power of two, >= 2
// ACK_TIMEOUT  16  cycles to wait for tx_ready to fall after tx_start before giving up on the ack
// PORTS
// clk          in   1         core clock
// rst          in   1         synchronous, active-high reset
// mmio_wen     in   1         write strobe, one cycle per write
// mmio_ren     in   1         read strobe
// mmio_addr    in   2         word offset: 0=DATA 1=STATUS 2=CTRL 3=reserved
// mmio_wdata   in   WORD_LEN  write data
// mmio_rdata   out  WORD_LEN  read data, registered
// tx_start     out  1         one-cycle start pulse to uart_tx
// tx_data      out  8         byte to send; stable from the start pulse until the next pop
// tx_ready     in   1         uart_tx idle/ready
// tx_empty     out  1         high when the FIFO is empty and the sequencer is IDLE (all sent)
// BEHAVIOUR
// - Interface: one clock `clk`; reset `rst` is synchronous and active-high.
// - Reset: FIFO empty, rd/wr pointers 0, state IDLE, tx_start=0, tx_data=0, mmio_rdata=0, enable=1, overflow=0, tx_empty=1.
// - Write DATA: push wdata[7:0]. Push is accepted when !full, or when a pop happens in the same cycle.
//   Otherwise the byte is dropped and sticky overflow is set.
// - Write CTRL: bit0=enable. bit1=flush: rd_ptr<=wr_ptr, count<=0; a byte already handed to uart_tx completes. bit2=1 clears overflow.
//   Flush and push in the same cycle: flush first, then the push is accepted, so count=1.
// - Read (1-cycle latency): mmio_rdata is valid the cycle after mmio_ren.
//   DATA reads 0. STATUS={..0, count[log2(DEPTH):0] at [15:8], overflow[3], busy[2], full[1], empty[0]}. CTRL={..0, enable[0]}.
// - Writes/reads to offset 3 are ignored and read 0.
// - count is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH. full when count==DEPTH.
// - Sequencer FSM:
//   IDLE:     if enable && !empty && tx_ready: pop, tx_data<=head, tx_start<=1 -> ACK
//   ACK:      tx_start<=0. If !tx_ready -> SENDING.
//             Else after ACK_TIMEOUT cycles in ACK -> IDLE (byte counted as sent).
//   SENDING:  wait tx_ready==1 -> IDLE. Minimum 3 cycles per byte.
// - busy = (state!=IDLE). Clearing enable mid-byte finishes the current byte; no further pops.
// - Simultaneous push+pop: count unchanged, both pointers advance.
// - rst asserted mid-byte: FSM to IDLE, FIFO cleared; the uart_tx line is its own concern.
// STRUCTURE
// - uart_pkg.vh (shared include): register offsets, STATUS/CTRL bit positions, FSM state encodings.
// - Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/flush, full/empty/count, show-ahead head output.
//   It is reusable for a later uart_rx_ctrl.
// - uart_tx_ctrl holds the register decode, overflow/enable flags, FSM and timeout counter.
// TESTING
// - After reset, read STATUS -> 0x00000001 (empty). tx_start stays 0 for 100 cycles. tx_empty=1.
// - Push 0x48,0x69 with a uart_tx model (ready low for 10 cycles after start)
//   -> two tx_start pulses, tx_data 0x48 then 0x69, and a second start only after ready returns. tx_empty=1 at end.
// - With enable=0, push DEPTH+1 bytes -> STATUS count=32, full=1, overflow=1.
//   Write CTRL=0x5 -> overflow clears and DEPTH bytes are sent in order, with no loss of byte 0.
// - Full FIFO with a pop in the same cycle as a DATA write -> push accepted, count stays 32, overflow stays 0.
// - tx_ready held high (no ack) -> FSM returns to IDLE after 16 cycles in ACK and the next byte starts.
// - Flush while SENDING with 5 bytes queued -> current byte completes, no further starts, STATUS count=0, busy falls.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller:
// register map, STATUS/CTRL bit positions and sequencer states.
package uart_tx_ctrl_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam int CT_EN      = 0;
   localparam int CT_FLUSH   = 1;
   localparam int CT_OVF_CLR = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACK     = 2'd1,
      S_SENDING = 2'd2
   } tx_state_e;

   function automatic logic [15:0] pack_status(
      input logic [7:0] cnt,
      input logic       ovf,
      input logic       busy,
      input logic       full,
      input logic       empty
   );
      logic [15:0] s;
      s = '0;
      s[ST_CNT_LSB +: 8] = cnt;
      s[ST_OVF]          = ovf;
      s[ST_BUSY]         = busy;
      s[ST_FULL]         = full;
      s[ST_EMPTY]        = empty;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Single-clock show-ahead FIFO with push/pop/flush and occupancy count.
// Flush drops queued entries; a push in the same cycle lands after it.
module uart_tx_ctrl_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             do_pop;
   logic             do_push;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A pop or a flush in the same cycle frees room for the push.
   assign do_push = push && (!full || do_pop || flush);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= CW'(do_push);
         end else begin
            if (do_pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// MMIO front end for uart_tx: register decode, byte FIFO and
// a start/ready sequencer that hands bytes over one at a time.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH       = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mmio_wen,
   input  logic                mmio_ren,
   input  logic [1:0]          mmio_addr,
   input  logic [WORD_LEN-1:0] mmio_wdata,
   output logic [WORD_LEN-1:0] mmio_rdata,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_ready,
   output logic                tx_empty
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(ACK_TIMEOUT) + 1;

   tx_state_e     state;
   logic [TW-1:0] timer;
   logic          enable;
   logic          overflow;

   logic          wr_data;
   logic          wr_ctrl;
   logic          flush;
   logic          pop;
   logic [7:0]    head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          busy;
   logic [15:0]   status;
   logic          unused_wdata;

   assign wr_data = mmio_wen && (mmio_addr == ADDR_DATA);
   assign wr_ctrl = mmio_wen && (mmio_addr == ADDR_CTRL);
   assign flush   = wr_ctrl && mmio_wdata[CT_FLUSH];
   assign busy    = (state != S_IDLE);
   assign pop     = !busy && enable && !empty && tx_ready;

   assign tx_empty     = empty && !busy;
   assign status       = pack_status(8'(count), overflow, busy,
                                     full, empty);
   assign unused_wdata = ^mmio_wdata[WORD_LEN-1:8];

   uart_tx_ctrl_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_data),
      .push_data (mmio_wdata[7:0]),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            enable <= mmio_wdata[CT_EN];
         end
         if (wr_ctrl && mmio_wdata[CT_OVF_CLR]) begin
            overflow <= 1'b0;
         end else if (wr_data && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Reads return pre-write state when a write hits the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         mmio_rdata <= '0;
      end else if (mmio_ren) begin
         case (mmio_addr)
            ADDR_STATUS: mmio_rdata <= WORD_LEN'(status);
            ADDR_CTRL:   mmio_rdata <= WORD_LEN'(enable);
            default:     mmio_rdata <= '0;
         endcase
      end else begin
         mmio_rdata <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         timer    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               tx_start <= 1'b0;
               if (pop) begin
                  tx_data  <= head;
                  tx_start <= 1'b1;
                  timer    <= '0;
                  state    <= S_ACK;
               end
            end
            S_ACK: begin
               tx_start <= 1'b0;
               if (!tx_ready) begin
                  state <= S_SENDING;
               end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                  state <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_SENDING: begin
               tx_start <= 1'b0;
               if (tx_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               tx_start <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: queue-based byte model, flight tracker
// for the uart_tx handshake, directed scenarios then random traffic.
module tb_uart_tx_ctrl;

   localparam int DEPTH = 32;
   localparam int TO    = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mmio_wen = 1'b0;
   logic        mmio_ren = 1'b0;
   logic [1:0]  mmio_addr = 2'd0;
   logic [31:0] mmio_wdata = 32'd0;
   logic [31:0] mmio_rdata;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        tx_empty;

   uart_tx_ctrl #(
      .WORD_LEN    (32),
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mmio_wen   (mmio_wen),
      .mmio_ren   (mmio_ren),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_rdata (mmio_rdata),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_empty   (tx_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] q[$];
   logic [7:0] started[$];
   bit         m_en = 1'b1;
   bit         m_ovf = 1'b0;
   bit         m_fl = 1'b0;
   bit         m_ack = 1'b0;
   int         m_edges = 0;
   logic [7:0] m_tdata = 8'd0;
   int         n_starts = 0;
   int         last_start = 0;
   int         prev_start = 0;

   bit noack = 1'b0;
   bit u_rand = 1'b0;
   int u_dly = 0;
   int u_len = 10;
   int u_wait = 0;
   int u_low = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  name, cyc, got, exp);
      end
   endtask

   task automatic step();
      int          pcnt;
      bit          exp_start;
      bit          s_full;
      bit          s_empty;
      logic [31:0] exp_rd;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         q.delete();
         m_en = 1'b1;
         m_ovf = 1'b0;
         m_fl = 1'b0;
         m_tdata = 8'd0;
         chk("rst_start", 32'(tx_start), 32'd0);
         chk("rst_rdata", mmio_rdata, 32'd0);
      end else begin
         pcnt = q.size();
         s_full = (pcnt == DEPTH);
         s_empty = (pcnt == 0);
         exp_start = !m_fl && m_en && !s_empty && tx_ready;
         if (mmio_ren) begin
            case (mmio_addr)
               2'd1: exp_rd = {16'h0, 8'(pcnt), 4'h0,
                               m_ovf, m_fl, s_full, s_empty};
               2'd2: exp_rd = {31'h0, m_en};
               default: exp_rd = 32'h0;
            endcase
            chk("rdata", mmio_rdata, exp_rd);
         end
         if (m_fl) begin
            if (!m_ack) begin
               m_edges++;
               if (!tx_ready) m_ack = 1'b1;
               else if (m_edges == TO) m_fl = 1'b0;
            end else if (tx_ready) begin
               m_fl = 1'b0;
            end
         end
         chk("tx_start", 32'(tx_start), 32'(exp_start));
         if (exp_start) begin
            m_tdata = q.pop_front();
            m_fl = 1'b1;
            m_ack = 1'b0;
            m_edges = 0;
         end
         if (mmio_wen && mmio_addr == 2'd0) begin
            if (pcnt < DEPTH || exp_start) q.push_back(mmio_wdata[7:0]);
            else m_ovf = 1'b1;
         end
         if (mmio_wen && mmio_addr == 2'd2) begin
            m_en = mmio_wdata[0];
            if (mmio_wdata[1]) q.delete();
            if (mmio_wdata[2]) m_ovf = 1'b0;
         end
      end
      chk("tx_data", 32'(tx_data), 32'(m_tdata));
      chk("tx_empty", 32'(tx_empty), 32'(q.size() == 0 && !m_fl));
      if (tx_start) begin
         started.push_back(tx_data);
         n_starts++;
         prev_start = last_start;
         last_start = cyc;
         if (!noack) begin
            u_wait = u_rand ? int'($urandom_range(0, 2)) : u_dly;
            u_low = u_rand ? int'($urandom_range(1, 12)) : u_len;
         end
      end
      if (u_wait > 0) begin
         tx_ready = 1'b1;
         u_wait--;
      end else if (u_low > 0) begin
         tx_ready = 1'b0;
         u_low--;
      end else begin
         tx_ready = 1'b1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      mmio_wen = 1'b1;
      mmio_addr = a;
      mmio_wdata = d;
      step();
      mmio_wen = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      mmio_ren = 1'b1;
      mmio_addr = a;
      step();
      d = mmio_rdata;
      mmio_ren = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic drain(input string name, input int max);
      int k;
      k = 0;
      while ((q.size() != 0 || m_fl) && k < max) begin
         step();
         k++;
      end
      checks++;
      if (q.size() != 0 || m_fl) begin
         failures++;
         $display("FAIL %s drain got=%0d queued exp=0", name, q.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  b[DEPTH+1];
      int          s0;
      int          n0;
      int          r;

      step();
      step();
      rst = 1'b0;
      rd(2'd1, d);
      chk("status_reset", d, 32'h0000_0001);
      idle(100);
      chk("no_start_100", 32'(n_starts), 32'd0);
      chk("empty_reset", 32'(tx_empty), 32'd1);

      u_dly = 0;
      u_len = 10;
      s0 = started.size();
      wr(2'd0, 32'h48);
      wr(2'd0, 32'h69);
      drain("hi", 200);
      chk("hi_byte0", 32'(started[s0]), 32'h48);
      chk("hi_byte1", 32'(started[s0+1]), 32'h69);
      chk("hi_gap", 32'(last_start - prev_start), 32'd12);
      chk("hi_empty", 32'(tx_empty), 32'd1);

      wr(2'd2, 32'h0);
      for (int i = 0; i <= DEPTH; i++) begin
         b[i] = 8'($urandom);
         wr(2'd0, 32'(b[i]));
      end
      rd(2'd1, d);
      chk("status_ovf", d, 32'h0000_200A);
      s0 = started.size();
      wr(2'd2, 32'h5);
      rd(2'd1, d);
      chk("status_ovf_clr", d, 32'h0000_2002);
      drain("ovf", 2000);
      chk("ovf_first", 32'(started[s0]), 32'(b[0]));
      chk("ovf_last", 32'(started[s0+DEPTH-1]), 32'(b[DEPTH-1]));
      chk("ovf_count", 32'(started.size() - s0), 32'(DEPTH));

      wr(2'd2, 32'h0);
      for (int i = 0; i < DEPTH; i++) wr(2'd0, 32'(i));
      wr(2'd2, 32'h1);
      wr(2'd0, 32'hA5);
      rd(2'd1, d);
      chk("status_full_pop", d, 32'h0000_2006);
      drain("full_pop", 2000);
      chk("full_pop_last", 32'(started[started.size()-1]), 32'hA5);

      noack = 1'b1;
      wr(2'd0, 32'h11);
      wr(2'd0, 32'h22);
      drain("noack", 200);
      chk("noack_gap", 32'(last_start - prev_start), 32'd17);
      noack = 1'b0;

      u_len = 20;
      for (int i = 0; i < 6; i++) wr(2'd0, 32'(8'h30 + i));
      idle(2);
      wr(2'd2, 32'h3);
      n0 = n_starts;
      idle(60);
      chk("flush_no_start", 32'(n_starts - n0), 32'd0);
      rd(2'd1, d);
      chk("status_flush", d, 32'h0000_0001);

      u_len = 10;
      for (int i = 0; i < 3; i++) wr(2'd0, 32'(8'h70 + i));
      idle(3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n0 = n_starts;
      idle(30);
      chk("rst_mid_no_start", 32'(n_starts - n0), 32'd0);

      u_rand = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 99));
         mmio_wen = (r < 35);
         mmio_wdata = $urandom;
         if (r < 28) mmio_addr = 2'd0;
         else if (r < 31) mmio_addr = 2'd2;
         else if (r < 35) mmio_addr = 2'd3;
         else mmio_addr = 2'($urandom_range(0, 3));
         if (mmio_wen && mmio_addr == 2'd2) begin
            mmio_wdata[0] = ($urandom_range(0, 7) != 0);
            mmio_wdata[1] = ($urandom_range(0, 15) == 0);
            mmio_wdata[2] = ($urandom_range(0, 3) == 0);
         end
         mmio_ren = ($urandom_range(0, 4) == 0);
         noack = ((i / 700) % 3 == 2);
         rst = ($urandom_range(0, 1499) == 0);
         step();
         mmio_wen = 1'b0;
         mmio_ren = 1'b0;
         rst = 1'b0;
      end
      noack = 1'b0;
      wr(2'd2, 32'h1);
      drain("random", 3000);
      rd(2'd1, d);
      chk("status_final", d, 32'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
